// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: h/v counters, sync, active flag and
// strobes, delayed by PIPE_DELAY enabled stages to match a pixel pipeline.
module vga_timing_gen #(
  parameter int H_AV       = 640,
  parameter int H_FP       = 16,
  parameter int H_SP       = 96,
  parameter int H_BP       = 48,
  parameter int V_AV       = 480,
  parameter int V_FP       = 10,
  parameter int V_SP       = 2,
  parameter int V_BP       = 33,
  parameter int HS_POL     = 0,
  parameter int VS_POL     = 0,
  parameter int PIPE_DELAY = 1,
  parameter int CW         = 10
) (
  input  logic          pixClk,
  input  logic          reset,
  input  logic          en,
  output logic          hSync,
  output logic          vSync,
  output logic          valid,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          lineStart,
  output logic          frameStart
);

  localparam int H_TOTAL = H_AV + H_FP + H_SP + H_BP;
  localparam int V_TOTAL = V_AV + V_FP + V_SP + V_BP;

  // Boundaries held one bit wider than the counters so H_TOTAL == 2**CW works
  localparam logic [CW:0] H_LAST = (CW+1)'(H_TOTAL - 1);
  localparam logic [CW:0] V_LAST = (CW+1)'(V_TOTAL - 1);
  localparam logic [CW:0] H_ACT  = (CW+1)'(H_AV);
  localparam logic [CW:0] V_ACT  = (CW+1)'(V_AV);
  localparam logic [CW:0] H_PS   = (CW+1)'(H_AV + H_FP);
  localparam logic [CW:0] H_PE   = (CW+1)'(H_AV + H_FP + H_SP);
  localparam logic [CW:0] V_PS   = (CW+1)'(V_AV + V_FP);
  localparam logic [CW:0] V_PE   = (CW+1)'(V_AV + V_FP + V_SP);

  localparam logic HS_ACT = HS_POL[0];
  localparam logic VS_ACT = VS_POL[0];

  typedef struct packed {
    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic          hp;
    logic          vp;
    logic          act;
    logic          ls;
    logic          fs;
  } tap_t;

  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;
  logic [CW:0]   h_ext, v_ext;
  logic          h_last, v_last;
  tap_t          raw;
  tap_t          pipe_q [PIPE_DELAY];
  tap_t          pipe_d [PIPE_DELAY];
  tap_t          last;

  assign h_ext  = {1'b0, h_cnt_q};
  assign v_ext  = {1'b0, v_cnt_q};
  assign h_last = (h_ext == H_LAST);
  assign v_last = (v_ext == V_LAST);

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (en) begin
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + CW'(1);
      end else begin
        h_cnt_d = h_cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    raw     = '0;
    raw.h   = h_cnt_q;
    raw.v   = v_cnt_q;
    raw.hp  = (h_ext >= H_PS) && (h_ext < H_PE);
    raw.vp  = (v_ext >= V_PS) && (v_ext < V_PE);
    raw.act = (h_ext < H_ACT) && (v_ext < V_ACT);
    raw.ls  = (h_cnt_q == '0);
    raw.fs  = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  // Stage 0 takes the live tuple; later stages take their predecessor
  always_comb begin
    pipe_d[0] = en ? raw : pipe_q[0];
    for (int i = 1; i < PIPE_DELAY; i++) begin
      pipe_d[i] = en ? pipe_q[i-1] : pipe_q[i];
    end
  end

  always_ff @(posedge pixClk) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      for (int i = 0; i < PIPE_DELAY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      for (int i = 0; i < PIPE_DELAY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign last       = pipe_q[PIPE_DELAY-1];
  assign hSync      = last.hp ? HS_ACT : ~HS_ACT;
  assign vSync      = last.vp ? VS_ACT : ~VS_ACT;
  assign valid      = last.act;
  assign x          = last.h;
  assign y          = last.v;
  assign lineStart  = last.ls && en;
  assign frameStart = last.fs && en;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: small 32x13 mode at two delays/polarities plus the
// default 800x525 mode, checked against a pixel-index model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset;
  logic en;

  always #5 clk = ~clk;

  logic       a_hs, a_vs, a_vld, a_ls, a_fs;
  logic [4:0] a_x, a_y;
  logic       b_hs, b_vs, b_vld, b_ls, b_fs;
  logic [4:0] b_x, b_y;
  logic       d_hs, d_vs, d_vld, d_ls, d_fs;
  logic [9:0] d_x, d_y;

  vga_timing_gen #(
    .H_AV(20), .H_FP(3), .H_SP(5), .H_BP(4),
    .V_AV(6), .V_FP(2), .V_SP(2), .V_BP(3),
    .HS_POL(0), .VS_POL(0), .PIPE_DELAY(1), .CW(5)
  ) u_a (
    .pixClk(clk), .reset(reset), .en(en),
    .hSync(a_hs), .vSync(a_vs), .valid(a_vld),
    .x(a_x), .y(a_y), .lineStart(a_ls), .frameStart(a_fs)
  );

  vga_timing_gen #(
    .H_AV(20), .H_FP(3), .H_SP(5), .H_BP(4),
    .V_AV(6), .V_FP(2), .V_SP(2), .V_BP(3),
    .HS_POL(1), .VS_POL(1), .PIPE_DELAY(3), .CW(5)
  ) u_b (
    .pixClk(clk), .reset(reset), .en(en),
    .hSync(b_hs), .vSync(b_vs), .valid(b_vld),
    .x(b_x), .y(b_y), .lineStart(b_ls), .frameStart(b_fs)
  );

  vga_timing_gen u_d (
    .pixClk(clk), .reset(reset), .en(en),
    .hSync(d_hs), .vSync(d_vs), .valid(d_vld),
    .x(d_x), .y(d_y), .lineStart(d_ls), .frameStart(d_fs)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int k      = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected {x,y,hs,vs,valid,ls,fs} after k enabled edges, mode 32x13
  function automatic logic [14:0] exp_vec(int kk, int pd, bit pol, bit e);
    int p, xx, yy;
    bit hp, vp, act, ls, fs;
    xx = 0; yy = 0; hp = 0; vp = 0; act = 0; ls = 0; fs = 0;
    if (kk >= pd) begin
      p   = (kk - pd) % 416;
      xx  = p % 32;
      yy  = p / 32;
      hp  = (xx >= 23) && (xx < 28);
      vp  = (yy >= 8) && (yy < 10);
      act = (xx < 20) && (yy < 6);
      ls  = (xx == 0);
      fs  = (xx == 0) && (yy == 0);
    end
    return {xx[4:0], yy[4:0], hp ? pol : ~pol, vp ? pol : ~pol,
            act, ls & e, fs & e};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (reset) k = 0;
    else if (en) k++;
    chk("a_vec", 32'({a_x, a_y, a_hs, a_vs, a_vld, a_ls, a_fs}),
        32'(exp_vec(k, 1, 1'b0, en)));
    chk("b_vec", 32'({b_x, b_y, b_hs, b_vs, b_vld, b_ls, b_fs}),
        32'(exp_vec(k, 3, 1'b1, en)));
  endtask

  task automatic wait_a_fs(string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      if (a_fs) ok = 1;
      else step();
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic measure(output int cyc, output int lsc,
                         output int vldc, output int vsc);
    cyc = 0; lsc = 0; vldc = 0; vsc = 0;
    do begin
      lsc  += int'(a_ls);
      vldc += int'(a_vld);
      vsc  += int'(!a_vs);
      cyc++;
      step();
    end while (!a_fs && cyc < 5000);
  endtask

  initial begin
    int  fall1, fall2, fx, lastx, low0, xmax, cyc, lsc, vldc, vsc;
    bit  prev_hs, found;

    reset = 1'b1;
    en    = 1'b1;
    step();
    chk("def_rst", 32'({d_x, d_y, d_hs, d_vs, d_vld, d_ls, d_fs}), 32'h18);
    chk("b_rst_idle", 32'({b_hs, b_vs}), 32'd0);

    reset = 1'b0;
    step();
    chk("def_fs_first", 32'(d_fs), 32'd1);
    chk("def_x0", 32'(d_x), 32'd0);

    fall1 = 0; fall2 = 0; fx = 0; lastx = 0; low0 = 0; xmax = 0;
    prev_hs = d_hs;
    for (int i = 2; i <= 1700; i++) begin
      step();
      if (prev_hs && !d_hs) begin
        if (fall1 == 0) begin
          fall1 = k;
          fx    = int'(d_x);
        end else if (fall2 == 0) begin
          fall2 = k;
        end
      end
      if (!d_hs && d_y == 10'd0) begin
        low0++;
        lastx = int'(d_x);
      end
      if (int'(d_x) > xmax) xmax = int'(d_x);
      prev_hs = d_hs;
    end
    chk("def_hs_first_x", 32'(fx), 32'd656);
    chk("def_hs_last_x", 32'(lastx), 32'd751);
    chk("def_hs_width", 32'(low0), 32'd96);
    chk("def_hs_period", 32'(fall2 - fall1), 32'd800);
    chk("def_xmax", 32'(xmax), 32'd799);

    wait_a_fs("fs_wait1");
    for (int f = 0; f < 2; f++) begin
      measure(cyc, lsc, vldc, vsc);
      chk("frame_len", 32'(cyc), 32'd416);
      chk("frame_ls", 32'(lsc), 32'd13);
      chk("frame_valid", 32'(vldc), 32'd120);
      chk("frame_vs_low", 32'(vsc), 32'd64);
    end

    cyc = 0; found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      step();
      cyc++;
      if (a_x == 5'd10 && a_y == 5'd3) found = 1;
    end
    chk("pause_reach", 32'(found), 32'd1);
    en = 1'b0;
    for (int i = 0; i < 37; i++) begin
      step();
      cyc++;
    end
    chk("pause_x", 32'(a_x), 32'd10);
    chk("pause_strobes", 32'({a_ls, a_fs, b_ls, b_fs}), 32'd0);
    en = 1'b1;
    step();
    cyc++;
    chk("resume_x", 32'(a_x), 32'd11);
    chk("resume_y", 32'(a_y), 32'd3);
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      step();
      cyc++;
      if (a_fs) found = 1;
    end
    chk("pause_fs_seen", 32'(found), 32'd1);
    chk("pause_frame_len", 32'(cyc), 32'd453);

    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      step();
      if (a_x == 5'd15 && a_y == 5'd4) found = 1;
    end
    chk("rst_reach", 32'(found), 32'd1);
    reset = 1'b1;
    step();
    chk("rst_a_xy", 32'({a_x, a_y}), 32'd0);
    chk("rst_a_idle", 32'({a_hs, a_vs, a_vld}), 32'h6);
    chk("rst_b_idle", 32'({b_hs, b_vs, b_vld}), 32'h0);
    reset = 1'b0;
    step();
    chk("rst_a_fs", 32'(a_fs), 32'd1);
    chk("rst_b_fs_early", 32'(b_fs), 32'd0);
    step();
    step();
    chk("rst_b_fs", 32'(b_fs), 32'd1);
    for (int i = 0; i < 40; i++) step();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
